spn_cu_top: RTL and testbench



---
 rtl/spn_cu_top_if.sv | 53 +++++
 rtl/spn_cu_top.sv | 132 +++++++++++++
 tb/tb_spn_cu_top.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/spn_cu_top_if.sv
// spn_cu_pkg: opcode/valid encodings. spn_if: command/result bundle for the SPN unit.
// Latency: none here (type and wire bundle only).
// Backpressure: none; a command is accepted every cycle.
// Ports: clk, rst (async active-low); opcode, data_in, symmetric_secret_key, data_out, valid.
package spn_cu_pkg;

  typedef enum logic [1:0] {
    no_op   = 2'b00,
    encrypt = 2'b01,
    decrypt = 2'b10
  } opcode_e;

  // Prefixed names keep these literals apart from opcode_e in the shared package scope.
  typedef enum logic [1:0] {
    valid_no_op           = 2'b00,
    successful_encryption = 2'b01,
    successful_decryption = 2'b10,
    valid_error           = 2'b11
  } valid_e;

endpackage

interface spn_if
  import spn_cu_pkg::*;
(
  input logic clk,
  input logic rst
);

  opcode_e     opcode;
  logic [15:0] data_in;
  logic [31:0] symmetric_secret_key;
  logic [15:0] data_out;
  valid_e      valid;

  // Cipher-unit side.
  modport dut (
    input  clk, rst, opcode, data_in, symmetric_secret_key,
    output data_out, valid
  );

  modport slave (
    input  clk, rst, opcode, data_in, symmetric_secret_key,
    output data_out, valid
  );

  // Command-issuer side.
  modport master (
    input  clk, rst, data_out, valid,
    output opcode, data_in, symmetric_secret_key
  );

endinterface

// File: rtl/spn_cu_top.sv
// 3-round 16-bit SPN encrypt/decrypt unit with 32-bit key and per-round debug taps.
// Latency: 1 cycle; inputs sampled at edge N are visible on the outputs after edge N.
// Backpressure: none; one command per cycle, no_op holds the previous results.
// Ports: clk, rst (async active-low), bus (spn_if.dut), key_mix_out/sbox_out/pbox_out[0:2].
module spn_cu_top
  import spn_cu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  spn_if.dut          bus,
  output logic [15:0] key_mix_out [0:2],
  output logic [15:0] sbox_out    [0:2],
  output logic [15:0] pbox_out    [0:2]
);

  function automatic logic [3:0] s_nib(input logic [3:0] x);
    case (x)
      4'h0: s_nib = 4'hE;  4'h1: s_nib = 4'h4;  4'h2: s_nib = 4'hD;  4'h3: s_nib = 4'h1;
      4'h4: s_nib = 4'h2;  4'h5: s_nib = 4'hF;  4'h6: s_nib = 4'hB;  4'h7: s_nib = 4'h8;
      4'h8: s_nib = 4'h3;  4'h9: s_nib = 4'hA;  4'hA: s_nib = 4'h6;  4'hB: s_nib = 4'hC;
      4'hC: s_nib = 4'h5;  4'hD: s_nib = 4'h9;  4'hE: s_nib = 4'h0;  default: s_nib = 4'h7;
    endcase
  endfunction

  function automatic logic [3:0] si_nib(input logic [3:0] x);
    case (x)
      4'h0: si_nib = 4'hE;  4'h1: si_nib = 4'h3;  4'h2: si_nib = 4'h4;  4'h3: si_nib = 4'h8;
      4'h4: si_nib = 4'h1;  4'h5: si_nib = 4'hC;  4'h6: si_nib = 4'hA;  4'h7: si_nib = 4'hF;
      4'h8: si_nib = 4'h7;  4'h9: si_nib = 4'hD;  4'hA: si_nib = 4'h9;  4'hB: si_nib = 4'h6;
      4'hC: si_nib = 4'hB;  4'hD: si_nib = 4'h2;  4'hE: si_nib = 4'h0;  default: si_nib = 4'h5;
    endcase
  endfunction

  function automatic logic [15:0] sub16(input logic [15:0] x, input logic inv);
    logic [15:0] o;
    o = '0;
    for (int n = 0; n < 4; n++) begin
      o[4*n +: 4] = inv ? si_nib(x[4*n +: 4]) : s_nib(x[4*n +: 4]);
    end
    return o;
  endfunction

  // Bit i lands on bit {i[1:0], i[3:2]}: a 4x4 transpose, so it is self-inverse.
  function automatic logic [15:0] perm16(input logic [15:0] x);
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[{i[1:0], i[3:2]}] = x[i];
    end
    return o;
  endfunction

  logic [15:0] rk [0:3];
  logic [15:0] enc_km [0:2], enc_sb [0:2], enc_pb [0:2];
  logic [15:0] dec_km [0:2], dec_sb [0:2], dec_pb [0:2];
  logic [15:0] enc_res;

  assign rk[0] = bus.symmetric_secret_key[15:0];
  assign rk[1] = bus.symmetric_secret_key[23:8];
  assign rk[2] = bus.symmetric_secret_key[31:16];
  assign rk[3] = {bus.symmetric_secret_key[7:0], bus.symmetric_secret_key[31:24]};

  always_comb begin
    logic [15:0] s;
    s = bus.data_in;
    for (int r = 0; r < 3; r++) begin
      enc_km[r] = s ^ rk[r];
      enc_sb[r] = sub16(enc_km[r], 1'b0);
      enc_pb[r] = perm16(enc_sb[r]);
      s         = enc_pb[r];
    end
    enc_res = s ^ rk[3];
  end

  // Decryption walks the rounds backwards, so round r uses key K(2-r).
  always_comb begin
    logic [15:0] s;
    s = bus.data_in ^ rk[3];
    for (int r = 0; r < 3; r++) begin
      dec_pb[r] = perm16(s);
      dec_sb[r] = sub16(dec_pb[r], 1'b1);
      dec_km[r] = dec_sb[r] ^ rk[2-r];
      s         = dec_km[r];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_out <= '0;
      bus.valid    <= valid_no_op;
      for (int r = 0; r < 3; r++) begin
        key_mix_out[r] <= '0;
        sbox_out[r]    <= '0;
        pbox_out[r]    <= '0;
      end
    end else begin
      case (bus.opcode)
        encrypt: begin
          bus.data_out <= enc_res;
          bus.valid    <= successful_encryption;
          for (int r = 0; r < 3; r++) begin
            key_mix_out[r] <= enc_km[r];
            sbox_out[r]    <= enc_sb[r];
            pbox_out[r]    <= enc_pb[r];
          end
        end
        decrypt: begin
          bus.data_out <= dec_km[2];
          bus.valid    <= successful_decryption;
          for (int r = 0; r < 3; r++) begin
            key_mix_out[r] <= dec_km[r];
            sbox_out[r]    <= dec_sb[r];
            pbox_out[r]    <= dec_pb[r];
          end
        end
        no_op: begin
          bus.valid <= valid_no_op;
        end
        default: begin
          bus.data_out <= '0;
          bus.valid    <= valid_error;
          for (int r = 0; r < 3; r++) begin
            key_mix_out[r] <= '0;
            sbox_out[r]    <= '0;
            pbox_out[r]    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spn_cu_top.sv
// Directed bench for spn_cu_top: reset, known vectors, random round-trips, error opcode, async reset.
// Latency: drives at negedge, samples 1 time unit after the following posedge.
// Backpressure: none exercised; the unit accepts a command every cycle.
module tb_spn_cu_top;
  import spn_cu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] key_mix_out [0:2];
  logic [15:0] sbox_out    [0:2];
  logic [15:0] pbox_out    [0:2];

  int checks = 0;
  int errors = 0;

  spn_if bus (.clk(clk), .rst(rst));

  spn_cu_top u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.dut),
    .key_mix_out (key_mix_out),
    .sbox_out    (sbox_out),
    .pbox_out    (pbox_out)
  );

  always #5 clk = ~clk;

  logic [3:0] s_tbl  [16] = '{4'hE,4'h4,4'hD,4'h1,4'h2,4'hF,4'hB,4'h8,4'h3,4'hA,4'h6,4'hC,4'h5,4'h9,4'h0,4'h7};
  logic [3:0] si_tbl [16] = '{4'hE,4'h3,4'h4,4'h8,4'h1,4'hC,4'hA,4'hF,4'h7,4'hD,4'h9,4'h6,4'hB,4'h2,4'h0,4'h5};

  function automatic logic [15:0] ref_s(input logic [15:0] x, input bit inv);
    logic [15:0] o;
    for (int n = 0; n < 4; n++) o[n*4 +: 4] = inv ? si_tbl[x[n*4 +: 4]] : s_tbl[x[n*4 +: 4]];
    return o;
  endfunction

  function automatic logic [15:0] ref_p(input logic [15:0] x);
    logic [15:0] o;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++) o[col*4 + row] = x[row*4 + col];
    return o;
  endfunction

  function automatic logic [15:0] ref_key(input logic [31:0] k, input int r);
    case (r)
      0:       return k[15:0];
      1:       return k[23:8];
      2:       return k[31:16];
      default: return {k[7:0], k[31:24]};
    endcase
  endfunction

  function automatic logic [15:0] ref_enc(input logic [15:0] d, input logic [31:0] k);
    logic [15:0] s;
    s = d;
    for (int r = 0; r < 3; r++) s = ref_p(ref_s(s ^ ref_key(k, r), 1'b0));
    return s ^ ref_key(k, 3);
  endfunction

  function automatic logic [15:0] ref_dec(input logic [15:0] c, input logic [31:0] k);
    logic [15:0] s;
    s = c ^ ref_key(k, 3);
    for (int r = 0; r < 3; r++) s = ref_s(ref_p(s), 1'b1) ^ ref_key(k, 2 - r);
    return s;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [1:0] op, input logic [15:0] d, input logic [31:0] k);
    @(negedge clk);
    bus.opcode               = opcode_e'(op);
    bus.data_in              = d;
    bus.symmetric_secret_key = k;
    @(posedge clk);
    #1;
  endtask

  task automatic check_debug_zero(input string tag);
    for (int r = 0; r < 3; r++) begin
      check($sformatf("%s km%0d", tag, r), key_mix_out[r], 16'h0000);
      check($sformatf("%s sb%0d", tag, r), sbox_out[r], 16'h0000);
      check($sformatf("%s pb%0d", tag, r), pbox_out[r], 16'h0000);
    end
  endtask

  logic [15:0] pt, ct;
  logic [31:0] key;

  initial begin
    bus.opcode               = no_op;
    bus.data_in              = '0;
    bus.symmetric_secret_key = '0;
    #12;
    check("rst data_out", bus.data_out, 16'h0000);
    check("rst valid", 16'(bus.valid), 16'(valid_no_op));
    check_debug_zero("rst");

    @(negedge clk);
    rst = 1'b1;
    apply(2'b00, 16'h1234, 32'h0);
    apply(2'b00, 16'h1234, 32'h0);
    check("noop data_out", bus.data_out, 16'h0000);
    check("noop valid", 16'(bus.valid), 16'(valid_no_op));
    check_debug_zero("noop");

    apply(2'b01, 16'h0000, 32'h0000_0000);
    check("enc km0", key_mix_out[0], 16'h0000);
    check("enc sb0", sbox_out[0], 16'hEEEE);
    check("enc pb0", pbox_out[0], 16'hFFF0);
    check("enc km1", key_mix_out[1], 16'hFFF0);
    check("enc sb1", sbox_out[1], 16'h777E);
    check("enc pb1", pbox_out[1], 16'h1FFE);
    check("enc km2", key_mix_out[2], 16'h1FFE);
    check("enc sb2", sbox_out[2], 16'h4770);
    check("enc pb2", pbox_out[2], 16'h0E66);
    check("enc data_out", bus.data_out, 16'h0E66);
    check("enc valid", 16'(bus.valid), 16'(successful_encryption));

    apply(2'b00, 16'hBEEF, 32'hFFFF_FFFF);
    check("hold data_out", bus.data_out, 16'h0E66);
    check("hold pb2", pbox_out[2], 16'h0E66);
    check("hold valid", 16'(bus.valid), 16'(valid_no_op));

    apply(2'b10, 16'h0E66, 32'h0000_0000);
    check("dec pb0", pbox_out[0], 16'h4770);
    check("dec sb0", sbox_out[0], 16'h1FFE);
    check("dec data_out", bus.data_out, 16'h0000);
    check("dec valid", 16'(bus.valid), 16'(successful_decryption));

    for (int i = 0; i < 10; i++) begin
      pt  = 16'($urandom);
      key = $urandom;
      ct  = ref_enc(pt, key);
      apply(2'b01, pt, key);
      check($sformatf("rnd%0d enc", i), bus.data_out, ct);
      check($sformatf("rnd%0d enc valid", i), 16'(bus.valid), 16'(successful_encryption));
      apply(2'b10, ct, key);
      check($sformatf("rnd%0d dec", i), bus.data_out, pt);
      check($sformatf("rnd%0d dec model", i), bus.data_out, ref_dec(ct, key));
      check($sformatf("rnd%0d dec valid", i), 16'(bus.valid), 16'(successful_decryption));
    end

    apply(2'b11, 16'h5A5A, 32'h1234_5678);
    check("err valid", 16'(bus.valid), 16'(valid_error));
    check("err data_out", bus.data_out, 16'h0000);
    check_debug_zero("err");

    apply(2'b01, 16'h0000, 32'h0000_0000);
    check("recover data_out", bus.data_out, 16'h0E66);
    check("recover valid", 16'(bus.valid), 16'(successful_encryption));

    // Still mid-cycle here: the clear must not wait for an edge.
    rst = 1'b0;
    #1;
    check("async rst data_out", bus.data_out, 16'h0000);
    check("async rst valid", 16'(bus.valid), 16'(valid_no_op));
    check("async rst pb2", pbox_out[2], 16'h0000);
    check("async rst km0", key_mix_out[0], 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
